// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: 4-state instruction sequencer with IR decode, ALU and 16x4 data memory
module exec_ctrl_unit #(
    parameter int DATA_W  = 4,
    parameter int MADDR_W = 4,
    parameter int RADDR_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [11:0]        IR,
    input  logic               isexternal,
    input  logic [DATA_W-1:0]  RF_d1,
    input  logic [DATA_W-1:0]  RF_d2,
    output logic               PC_enable,
    output logic [RADDR_W-1:0] RF_ad1,
    output logic [RADDR_W-1:0] RF_ad2,
    output logic [RADDR_W-1:0] RF_wa,
    output logic               RF_we,
    output logic               Mux_select,
    output logic [DATA_W-1:0]  ALU_out,
    output logic [DATA_W-1:0]  M_rd
);
    typedef enum logic [1:0] {WAIT1, WAIT2, EXEC, FETCH} state_t;

    state_t            r_state;
    logic              r_pc_en;
    logic              r_rf_we;
    logic              r_mem_we;
    logic              r_mem_re;
    logic [DATA_W-1:0] r_mem [2**MADDR_W];

    logic [2:0]         w_op;
    logic [MADDR_W-1:0] w_maddr;
    logic               w_is_mem;

    assign w_op     = IR[11:9];
    assign w_maddr  = IR[MADDR_W-1:0];
    assign w_is_mem = (w_op == 3'b000) || (w_op == 3'b001);

    assign RF_ad1     = w_is_mem ? IR[8:6] : IR[5:3];
    assign RF_ad2     = w_is_mem ? '0 : IR[2:0];
    assign RF_wa      = IR[8:6];
    assign Mux_select = (w_op == 3'b001);
    assign PC_enable  = r_pc_en;
    assign RF_we      = r_rf_we;
    assign M_rd       = r_mem_re ? r_mem[w_maddr] : '0;

    // Sequencer: enables are computed one edge ahead so they are registered for the state they belong to
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= WAIT1;
            r_pc_en  <= 1'b0;
            r_rf_we  <= 1'b0;
            r_mem_we <= 1'b0;
            r_mem_re <= 1'b0;
        end else begin
            r_state  <= state_t'(r_state + 2'd1);
            r_rf_we  <= (r_state == WAIT2) && (w_op != 3'b000);
            r_mem_we <= (r_state == WAIT2) && (w_op == 3'b000);
            r_mem_re <= (r_state == WAIT2) && (w_op == 3'b001);
            r_pc_en  <= (r_state == EXEC) && !isexternal;
        end
    end

    // Data memory: cleared on reset, written at the end of a STORE's EXEC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**MADDR_W; i++) r_mem[i] <= '0;
        end else if (r_mem_we) begin
            r_mem[w_maddr] <= RF_d1;
        end
    end

    // ALU: wraps modulo 2**DATA_W; LOAD/STORE pass A through
    always_comb begin
        ALU_out = RF_d1;
        case (w_op)
            3'b010:  ALU_out = RF_d1 + RF_d2;
            3'b011:  ALU_out = RF_d1 - RF_d2;
            3'b100:  ALU_out = RF_d1 & RF_d2;
            3'b101:  ALU_out = RF_d1 | RF_d2;
            3'b110:  ALU_out = RF_d1 ^ RF_d2;
            3'b111:  ALU_out = ~RF_d1;
            default: ALU_out = RF_d1;
        endcase
    end
endmodule

// File: tb/tb_exec_ctrl_unit.sv
// tb_exec_ctrl_unit: directed instruction sequences checked with immediate assertions
module tb_exec_ctrl_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] IR;
    logic        isexternal;
    logic [3:0]  RF_d1, RF_d2;
    logic        PC_enable, RF_we, Mux_select;
    logic [2:0]  RF_ad1, RF_ad2, RF_wa;
    logic [3:0]  ALU_out, M_rd;
    int          n_vec = 0;
    int          n_err = 0;

    exec_ctrl_unit dut (
        .clk(clk), .rst(rst), .IR(IR), .isexternal(isexternal),
        .RF_d1(RF_d1), .RF_d2(RF_d2), .PC_enable(PC_enable),
        .RF_ad1(RF_ad1), .RF_ad2(RF_ad2), .RF_wa(RF_wa), .RF_we(RF_we),
        .Mux_select(Mux_select), .ALU_out(ALU_out), .M_rd(M_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called at WAIT1 (#1 after edge); returns at WAIT1 of the next instruction
    task automatic run(input string tag, input logic [11:0] ir, input logic [3:0] d1, input logic [3:0] d2,
                       input logic ext, input logic [3:0] e_alu, input logic [2:0] e_ad1,
                       input logic [2:0] e_ad2, input logic [2:0] e_wa, input logic e_we,
                       input logic e_mux, input logic [3:0] e_mrd);
        IR = ir; RF_d1 = d1; RF_d2 = d2; isexternal = ext;
        #1;
        chk({tag, ".w1_pc"}, {7'd0, PC_enable}, 8'd0);
        chk({tag, ".w1_we"}, {7'd0, RF_we}, 8'd0);
        @(posedge clk); #1;
        chk({tag, ".w2_we"}, {7'd0, RF_we}, 8'd0);
        @(posedge clk); #1;
        chk({tag, ".ex_we"}, {7'd0, RF_we}, {7'd0, e_we});
        chk({tag, ".ex_pc"}, {7'd0, PC_enable}, 8'd0);
        chk({tag, ".alu"}, {4'd0, ALU_out}, {4'd0, e_alu});
        chk({tag, ".ad1"}, {5'd0, RF_ad1}, {5'd0, e_ad1});
        chk({tag, ".ad2"}, {5'd0, RF_ad2}, {5'd0, e_ad2});
        chk({tag, ".wa"}, {5'd0, RF_wa}, {5'd0, e_wa});
        chk({tag, ".mux"}, {7'd0, Mux_select}, {7'd0, e_mux});
        chk({tag, ".mrd"}, {4'd0, M_rd}, {4'd0, e_mrd});
        @(posedge clk); #1;
        chk({tag, ".f_pc"}, {7'd0, PC_enable}, {7'd0, !ext});
        chk({tag, ".f_we"}, {7'd0, RF_we}, 8'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; IR = 12'b000_000_00_0000; isexternal = 1'b0; RF_d1 = 4'd0; RF_d2 = 4'd0;
        #2;
        chk("rst.pc", {7'd0, PC_enable}, 8'd0);
        chk("rst.we", {7'd0, RF_we}, 8'd0);
        chk("rst.mrd", {4'd0, M_rd}, 8'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // first instruction after reset: no enables for 3 cycles, PC pulse on 4th
        run("st0",  12'b000_000_00_0000, 4'd0,     4'd0,     1'b0, 4'd0,     3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 4'd0);
        run("add",  12'b010_011_001_010, 4'd7,     4'd12,    1'b0, 4'd3,     3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 4'd0);
        run("sub",  12'b011_000_001_010, 4'd2,     4'd5,     1'b0, 4'd13,    3'd1, 3'd2, 3'd0, 1'b1, 1'b0, 4'd0);
        run("and",  12'b100_001_010_011, 4'b1010, 4'b0110, 1'b0, 4'b0010, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 4'd0);
        run("or",   12'b101_100_110_111, 4'b1010, 4'b0110, 1'b0, 4'b1110, 3'd6, 3'd7, 3'd4, 1'b1, 1'b0, 4'd0);
        run("xor",  12'b110_111_000_001, 4'b1010, 4'b0110, 1'b0, 4'b1100, 3'd0, 3'd1, 3'd7, 1'b1, 1'b0, 4'd0);
        run("not",  12'b111_010_101_100, 4'b1010, 4'b0110, 1'b0, 4'b0101, 3'd5, 3'd4, 3'd2, 1'b1, 1'b0, 4'd0);
        run("st9",  12'b000_101_00_1001, 4'd6,     4'd3,     1'b0, 4'd6,     3'd5, 3'd0, 3'd5, 1'b0, 1'b0, 4'd0);
        run("ld9",  12'b001_010_00_1001, 4'd1,     4'd3,     1'b0, 4'd1,     3'd2, 3'd0, 3'd2, 1'b1, 1'b1, 4'd6);
        run("ld3",  12'b001_110_00_0011, 4'd0,     4'd0,     1'b0, 4'd0,     3'd6, 3'd0, 3'd6, 1'b1, 1'b1, 4'd0);
        run("st12", 12'b000_011_11_1100, 4'd15,    4'd0,     1'b0, 4'd15,    3'd3, 3'd0, 3'd3, 1'b0, 1'b0, 4'd0);
        // external mode: no PC advance, writes still happen
        run("ex1",  12'b010_001_010_011, 4'd9,     4'd9,     1'b1, 4'd2,     3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 4'd0);
        run("ex2",  12'b010_001_010_011, 4'd9,     4'd9,     1'b1, 4'd2,     3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 4'd0);
        run("ex3",  12'b001_100_00_1100, 4'd0,     4'd0,     1'b1, 4'd0,     3'd4, 3'd0, 3'd4, 1'b1, 1'b1, 4'd15);
        run("ld9b", 12'b001_010_00_1001, 4'd0,     4'd0,     1'b0, 4'd0,     3'd2, 3'd0, 3'd2, 1'b1, 1'b1, 4'd6);
        // reset asserted during EXEC of a STORE to address 4
        IR = 12'b000_000_00_0100; RF_d1 = 4'd9; isexternal = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid.pc", {7'd0, PC_enable}, 8'd0);
        chk("mid.we", {7'd0, RF_we}, 8'd0);
        @(posedge clk); #1 rst = 1'b0;
        run("ld4",  12'b001_000_00_0100, 4'd0,     4'd0,     1'b0, 4'd0,     3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 4'd0);
        run("ld9c", 12'b001_010_00_1001, 4'd0,     4'd0,     1'b0, 4'd0,     3'd2, 3'd0, 3'd2, 1'b1, 1'b1, 4'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
